cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
Bridges the L1 cache line interface to the 64-bit burst physical-memory interface. It is the responder the L1 I-cache miss path talks to. It accepts one whole-line read or write request, runs a 4-beat burst to memory, then signals completion to the cache with a single-cycle resp_o. Read lines return on line_o for the cache's data/tag/valid load path.

Parameters:
LINE_WIDTH, 256, cache line width in bits.
BURST_WIDTH, 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH = 4.
ADDR_WIDTH, 32, byte address width.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst  in  1  reset; synchronous, active-high.
address_i  in  ADDR_WIDTH  cache line address.
read_i  in  1  cache line read request; held until resp_o.
write_i  in  1  cache line write request; held until resp_o.
line_i  in  LINE_WIDTH  write line data; sampled at accept.
line_o  out  LINE_WIDTH  assembled read line.
resp_o  out  1  one-cycle completion pulse to the cache.
address_o  out  ADDR_WIDTH  line-aligned burst address to memory.
read_o  out  1  memory burst read.
write_o  out  1  memory burst write.
burst_o  out  BURST_WIDTH  write beat data.
burst_i  in  BURST_WIDTH  read beat data.
resp_i  in  1  memory beat acknowledge; one per beat.

Behaviour:
- Reset (rst high at an edge): state IDLE; beat count 0; read_o, write_o and resp_o are 0; address_o, burst_o and line_o are 0.
- Reset has priority over all other inputs, including reset in the middle of a burst. Any in-flight request is dropped with no resp_o. Memory strobes fall in the cycle after the reset edge.
- Burst address: address_o is the latched address_i with its low log2(LINE_WIDTH/8) = 5 bits cleared. It is held constant for the whole burst.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch address_i and line_i, clear count, go to WRITE. Write has priority if read_i and write_i are both high.
  - Otherwise read_i=1: latch address_i, clear count, go to READ.
  - resp_i is ignored in IDLE.
- READ:
  - read_o=1.
  - On each edge with resp_i=1: burst_i is stored into line bits [count*64 +: 64], with beat 0 as the least significant. Count then increments.
  - The edge with resp_i=1 and count=3 moves to DONE.
  - resp_i=0 holds state and count; wait states are unbounded.
- WRITE:
  - write_o=1; burst_o = latched line [count*64 +: 64].
  - resp_i=1 advances count; the 4th acknowledge moves to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o and write_o are 0; then go to IDLE.
  - line_o is valid in DONE and holds until the next read's first beat is captured.
- Request handoff: requests are only accepted in IDLE. The cache must drop read_i/write_i in the cycle after resp_o; the earliest re-accept is the IDLE cycle after DONE.
- Minimum latency, read or write: request seen at edge 0; strobe high cycles 1–4 with zero-wait acknowledges; resp_o in cycle 5.
- Count is 2 bits and wraps 3→0 on the last beat. Its exit condition is state-qualified, not a wrap detect.
- Input changes to address_i or line_i during a burst have no effect, since both are latched.

Decomposition:
- Package cacheline_adaptor_types: state enum {IDLE, READ, WRITE, DONE}; constants BEATS=4, BEAT_IDX_W=2, OFFSET_BITS=5.
- Sub-module burst_counter: 2-bit counter with clear, increment-on-ack, and a last_beat output (count==3). Instantiate it once.
- The FSM and beat mux/demux stay in the top level.

Test Plan:
- Read, zero wait:
  - Stimulus: rst, then read_i=1 with address_i=0x0000_1234; resp_i high 4 cycles with burst_i 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: address_o=0x0000_1220; read_o high cycles 1–4; resp_o in cycle 5 only.
  - Required: line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with wait states:
  - Stimulus: write_i=1 with line_i = {64'hD, 64'hC, 64'hB, 64'hA}; resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o stays 0xA until the 1st acknowledge, then 0xB, 0xC, 0xD in order.
  - Required: write_o is low and resp_o pulses once, in the cycle after the 4th acknowledge.
- Simultaneous read_i=1 and write_i=1 -> WRITE path taken; read_o never asserts.
- Reset mid-read: rst at beat 2 -> read_o=0 in the next cycle and no resp_o. A following new read captures beat 0 at line_o[63:0] again.
- Back-to-back:
  - Stimulus: a second read issued the cycle after resp_o.
  - Required: it is accepted from IDLE; the prior line_o is held until the new first beat.
  - Required: resp_i pulses while IDLE are ignored, with no state change.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache line to burst memory bridge.
// Line is moved as four 64-bit beats, beat 0 in the low bits.
package cacheline_adaptor_types;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  localparam int BEATS       = 4;
  localparam int BEAT_IDX_W  = 2;
  localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/burst_counter.sv
// Beat index for one memory burst: clear on accept, step on each ack.
// last_o flags the final beat so the owner can leave the burst state.
module burst_counter
  import cacheline_adaptor_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [BEAT_IDX_W-1:0] count_o,
  output logic                  last_o
);

  logic [BEAT_IDX_W-1:0] count_q;
  logic [BEAT_IDX_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + BEAT_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == BEAT_IDX_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_adaptor.sv
// Bridges whole-line cache requests to a 4-beat 64-bit memory burst.
// Completion is a single-cycle resp_o after the last beat is acknowledged.
module cacheline_adaptor
  import cacheline_adaptor_types::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  state_e                 state_q;
  state_e                 state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  wline_q;
  logic [LINE_WIDTH-1:0]  rline_q;
  logic [BEAT_IDX_W-1:0]  cnt;
  logic                   last_beat;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   accept;
  logic                   accept_wr;
  logic [BURST_WIDTH-1:0] beat_mux;

  burst_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .last_o  (last_beat)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    accept    = 1'b0;
    accept_wr = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // write wins when both requests are raised together
        if (write_i) begin
          state_d   = WRITE;
          accept    = 1'b1;
          accept_wr = 1'b1;
        end else if (read_i) begin
          state_d = READ;
          accept  = 1'b1;
        end
        cnt_clr = accept;
      end
      READ: begin
        read_o  = 1'b1;
        cnt_inc = resp_i;
        if (resp_i && last_beat) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        cnt_inc = resp_i;
        if (resp_i && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    beat_mux = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == BEAT_IDX_W'(b)) begin
        beat_mux = wline_q[b*BURST_WIDTH +: BURST_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= {address_i[ADDR_WIDTH-1:OFFSET_BITS],
                   OFFSET_BITS'(0)};
      end
      if (accept_wr) begin
        wline_q <= line_i;
      end
      // read line is only overwritten beat by beat, so it holds between bursts
      if (state_q == READ && resp_i) begin
        for (int b = 0; b < BEATS; b++) begin
          if (cnt == BEAT_IDX_W'(b)) begin
            rline_q[b*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
          end
        end
      end
    end
  end

  assign address_o = addr_q;
  assign line_o    = rline_q;
  assign burst_o   = (state_q == WRITE) ? beat_mux : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: directed cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = '0;
  logic         resp_i = 1'b0;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // model: pending transaction, acks so far, captured/latched beats
  bit          m_busy = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_done = 1'b0;
  int          m_acks = 0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_wl[4];
  logic [63:0] m_rl[4];
  int          ndone = 0;

  logic [63:0] expb[7];
  bit          pat[7];
  logic [255:0] prev_line;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  task automatic chk(input string n, input logic [255:0] a,
                     input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_acks = 0;
      m_addr = '0;
      for (int i = 0; i < 4; i++) begin
        m_wl[i] = '0;
        m_rl[i] = '0;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (resp_i) begin
        if (!m_wr) m_rl[m_acks] = burst_i;
        m_acks++;
        if (m_acks == 4) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          ndone++;
        end
      end
    end else if (write_i || read_i) begin
      m_busy = 1'b1;
      m_wr   = write_i;
      m_acks = 0;
      m_addr = address_i & 32'hFFFF_FFE0;
      if (write_i) begin
        for (int i = 0; i < 4; i++) m_wl[i] = line_i[i*64 +: 64];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic finish_req();
    int n = 0;
    resp_i = 1'b1;
    while (resp_o !== 1'b1 && n < 20) begin
      burst_i = {$urandom, $urandom};
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL finish_bound actual=no_resp required=resp_o");
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("read_o", read_o, m_busy && !m_wr);
        chk("write_o", write_o, m_busy && m_wr);
        chk("resp_o", resp_o, m_done);
        chk("address_o", address_o, m_addr);
        chk("line_o", line_o, {m_rl[3], m_rl[2], m_rl[1], m_rl[0]});
        if (m_busy && m_wr) chk("burst_o", burst_o, m_wl[m_acks]);
      end
    end
  end

  initial begin
    expb = '{64'hA, 64'hB, 64'hB, 64'hB, 64'hC, 64'hD, 64'hD};
    pat  = '{1, 0, 0, 1, 1, 0, 1};

    // reset state
    tick();
    tick();
    chk_en = 1'b1;
    at_neg();
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_addr", address_o, 32'h0);
    chk("rst_line", line_o, 256'h0);
    chk("rst_burst", burst_o, 64'h0);
    tick();
    rst = 1'b0;

    // read, zero wait
    address_i = 32'h0000_1234;
    read_i = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      burst_i = {16{4'(k + 1)}};
      at_neg();
      chk("rd_strobe", read_o, 1'b1);
      chk("rd_addr", address_o, 32'h0000_1220);
      chk("rd_noresp", resp_o, 1'b0);
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    at_neg();
    chk("rd_resp", resp_o, 1'b1);
    chk("rd_strobe_off", read_o, 1'b0);
    chk("rd_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    tick();
    at_neg();
    chk("rd_resp_1cyc", resp_o, 1'b0);

    // write with wait states
    line_i = {64'hD, 64'hC, 64'hB, 64'hA};
    write_i = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      resp_i = pat[k];
      at_neg();
      chk("wr_beat", burst_o, expb[k]);
      chk("wr_strobe", write_o, 1'b1);
      tick();
    end
    resp_i = 1'b0;
    write_i = 1'b0;
    at_neg();
    chk("wr_resp", resp_o, 1'b1);
    chk("wr_strobe_off", write_o, 1'b0);
    tick();

    // simultaneous read and write: write wins
    read_i = 1'b1;
    write_i = 1'b1;
    line_i = {64'h4, 64'h3, 64'h2, 64'h1};
    tick();
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      at_neg();
      chk("both_no_read", read_o, 1'b0);
      chk("both_write", write_o, 1'b1);
      chk("both_beat", burst_o, 64'(k + 1));
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    write_i = 1'b0;
    at_neg();
    chk("both_resp", resp_o, 1'b1);
    tick();

    // reset in the middle of a read
    address_i = 32'h0000_0080;
    read_i = 1'b1;
    tick();
    resp_i = 1'b1;
    burst_i = 64'h1;
    tick();
    burst_i = 64'h2;
    tick();
    rst = 1'b1;
    read_i = 1'b0;
    tick();
    rst = 1'b0;
    resp_i = 1'b0;
    at_neg();
    chk("rstmid_read_o", read_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      at_neg();
      chk("rstmid_no_resp", resp_o, 1'b0);
    end
    tick();
    address_i = 32'h0000_0040;
    read_i = 1'b1;
    tick();
    resp_i = 1'b1;
    burst_i = 64'hCAFE;
    tick();
    resp_i = 1'b0;
    at_neg();
    chk("rstmid_beat0", line_o[63:0], 64'hCAFE);
    chk("rstmid_upper", line_o[255:64], 192'h0);
    tick();
    finish_req();

    // idle resp_i pulses are ignored
    for (int k = 0; k < 3; k++) begin
      resp_i = 1'b1;
      tick();
      at_neg();
      chk("idle_ack_read", read_o, 1'b0);
      chk("idle_ack_resp", resp_o, 1'b0);
    end
    resp_i = 1'b0;

    // back-to-back reads
    address_i = 32'h0000_0100;
    read_i = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      burst_i = 64'h100 + 64'(k);
      tick();
    end
    prev_line = {64'h103, 64'h102, 64'h101, 64'h100};
    read_i = 1'b0;
    at_neg();
    chk("b2b_resp", resp_o, 1'b1);
    tick();
    read_i = 1'b1;
    address_i = 32'h0000_0200;
    at_neg();
    chk("b2b_idle", read_o, 1'b0);
    tick();
    resp_i = 1'b0;
    at_neg();
    chk("b2b_accept", read_o, 1'b1);
    chk("b2b_addr", address_o, 32'h0000_0200);
    chk("b2b_hold", line_o, prev_line);
    tick();
    resp_i = 1'b1;
    burst_i = 64'hBEEF;
    tick();
    resp_i = 1'b0;
    at_neg();
    chk("b2b_first", line_o, {prev_line[255:64], 64'hBEEF});
    tick();
    finish_req();

    // randomized traffic
    ndone = 0;
    for (int c = 0; c < 4000; c++) begin
      address_i = $urandom;
      for (int i = 0; i < 8; i++) line_i[i*32 +: 32] = $urandom;
      burst_i = {$urandom, $urandom};
      resp_i = ($urandom_range(0, 2) != 0);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        read_i = 1'b0;
        write_i = 1'b0;
      end else if (resp_o) begin
        read_i = 1'b0;
        write_i = 1'b0;
      end else if (!read_i && !write_i && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: read_i = 1'b1;
          1: write_i = 1'b1;
          default: begin
            read_i = 1'b1;
            write_i = 1'b1;
          end
        endcase
      end
      tick();
    end
    if (ndone < 50) begin
      total++;
      bad++;
      $display("FAIL rand_progress actual=%0d required=>=50", ndone);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
